// File: rtl/alu_op_issue.sv
// alu_op_issue: sequential issue/decode front end for a 64-bit RISC-V ALU.
// Takes one instruction at a time, decodes it to the ALU opcode and operand-2
// source, drives the ALU from registers for SETTLE_CYC cycles, captures the
// result and hands it downstream over a valid/ready handshake.
//
//  state  | meaning
//  IDLE   | waiting for an instruction, in_ready high
//  DECODE | instruction latched, decode evaluated this cycle
//  EXEC   | ALU inputs held stable, settle counter running down
//  DONE   | result presented, waiting for out_ready
module alu_op_issue #(
    parameter int XLEN       = 64,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic [3:0]      alu_opr,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_branch_mux,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [1:0]      out_kind,
    output logic [4:0]      out_rd,
    output logic            out_branch_taken,
    output logic            out_illegal
);

    localparam int             CW       = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYC);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [3:0]     OPR_NOP  = 4'hF;
    localparam logic [1:0]     K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_BRANCH = 2'd3;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      alu_opr_q, alu_opr_d;
    logic [XLEN-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [1:0]      out_kind_q, out_kind_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_branch_taken_q, out_branch_taken_d;
    logic            out_illegal_q, out_illegal_d;

    logic            dec_legal;
    logic [3:0]      dec_opr;
    logic [XLEN-1:0] dec_in2;
    logic [1:0]      dec_kind;
    logic [4:0]      dec_rd;
    logic            exec_last;

    // rs1 register-number field is not needed: rs1 arrives as data
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr_q[19:15];

    wire [6:0]      opcode = instr_q[6:0];
    wire [2:0]      funct3 = instr_q[14:12];
    wire [6:0]      funct7 = instr_q[31:25];
    wire [XLEN-1:0] imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    wire [XLEN-1:0] imm_s  = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    wire [XLEN-1:0] shamt  = {{(XLEN-6){1'b0}}, instr_q[25:20]};

    assign exec_last = (state_q == EXEC) && (cnt_q == CNT_ONE);

    // Decode of the latched instruction into ALU opcode, operand 2, kind and rd
    always_comb begin
        dec_legal = 1'b0;
        dec_opr   = OPR_NOP;
        dec_in2   = rs2_q;
        dec_kind  = K_ALU;
        dec_rd    = 5'd0;
        case (opcode)
            7'b0110011: begin
                dec_rd = instr_q[11:7];
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'h00) begin dec_legal = 1'b1; dec_opr = 4'h0; end
                        else if (funct7 == 7'h20) begin dec_legal = 1'b1; dec_opr = 4'h1; end
                    end
                    3'b001: begin dec_legal = (funct7 == 7'h00); dec_opr = 4'h2; end
                    3'b100: begin dec_legal = (funct7 == 7'h00); dec_opr = 4'h3; end
                    3'b101: begin dec_legal = (funct7 == 7'h00); dec_opr = 4'h4; end
                    3'b110: begin dec_legal = (funct7 == 7'h00); dec_opr = 4'h5; end
                    3'b111: begin dec_legal = (funct7 == 7'h00); dec_opr = 4'h6; end
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_rd  = instr_q[11:7];
                dec_in2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_opr = 4'h0; end
                    3'b100: begin dec_legal = 1'b1; dec_opr = 4'h3; end
                    3'b110: begin dec_legal = 1'b1; dec_opr = 4'h5; end
                    3'b111: begin dec_legal = 1'b1; dec_opr = 4'h6; end
                    3'b001: begin dec_legal = (instr_q[31:26] == 6'd0); dec_opr = 4'h2; dec_in2 = shamt; end
                    3'b101: begin dec_legal = (instr_q[31:26] == 6'd0); dec_opr = 4'h4; dec_in2 = shamt; end
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec_legal = 1'b1; dec_opr = 4'h0; dec_in2 = imm_i;
                dec_kind  = K_LOAD; dec_rd = instr_q[11:7];
            end
            7'b0100011: begin
                dec_legal = 1'b1; dec_opr = 4'h0; dec_in2 = imm_s; dec_kind = K_STORE;
            end
            7'b1100011: begin
                dec_kind = K_BRANCH;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_opr = 4'h7; end
                    3'b001: begin dec_legal = 1'b1; dec_opr = 4'h8; end
                    3'b100: begin dec_legal = 1'b1; dec_opr = 4'h9; end
                    3'b101: begin dec_legal = 1'b1; dec_opr = 4'hA; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = DECODE;
            DECODE:  state_d = dec_legal ? EXEC : DONE;
            EXEC:    if (exec_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);
    end

    // Datapath next values: latch on accept, load ALU on DECODE->EXEC, capture on last EXEC edge
    always_comb begin
        instr_d            = instr_q;
        rs1_d              = rs1_q;
        rs2_d              = rs2_q;
        cnt_d              = cnt_q;
        alu_opr_d          = alu_opr_q;
        alu_in1_d          = alu_in1_q;
        alu_in2_d          = alu_in2_q;
        out_result_d       = out_result_q;
        out_kind_d         = out_kind_q;
        out_rd_d           = out_rd_q;
        out_branch_taken_d = out_branch_taken_q;
        out_illegal_d      = out_illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    rs1_d   = in_rs1_data;
                    rs2_d   = in_rs2_data;
                end
            end
            DECODE: begin
                out_kind_d         = dec_legal ? dec_kind : K_ALU;
                out_rd_d           = dec_legal ? dec_rd : 5'd0;
                out_illegal_d      = !dec_legal;
                out_result_d       = '0;
                out_branch_taken_d = 1'b0;
                if (dec_legal) begin
                    cnt_d     = CNT_LOAD;
                    alu_opr_d = dec_opr;
                    alu_in1_d = rs1_q;
                    alu_in2_d = dec_in2;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (exec_last) begin
                    alu_opr_d          = OPR_NOP;
                    out_result_d       = (out_kind_q == K_BRANCH) ? '0 : alu_result;
                    out_branch_taken_d = (out_kind_q == K_BRANCH) && !alu_branch_mux;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q            <= '0;
            rs1_q              <= '0;
            rs2_q              <= '0;
            cnt_q              <= '0;
            alu_opr_q          <= OPR_NOP;
            alu_in1_q          <= '0;
            alu_in2_q          <= '0;
            out_result_q       <= '0;
            out_kind_q         <= K_ALU;
            out_rd_q           <= 5'd0;
            out_branch_taken_q <= 1'b0;
            out_illegal_q      <= 1'b0;
        end else begin
            instr_q            <= instr_d;
            rs1_q              <= rs1_d;
            rs2_q              <= rs2_d;
            cnt_q              <= cnt_d;
            alu_opr_q          <= alu_opr_d;
            alu_in1_q          <= alu_in1_d;
            alu_in2_q          <= alu_in2_d;
            out_result_q       <= out_result_d;
            out_kind_q         <= out_kind_d;
            out_rd_q           <= out_rd_d;
            out_branch_taken_q <= out_branch_taken_d;
            out_illegal_q      <= out_illegal_d;
        end
    end

    assign alu_opr          = alu_opr_q;
    assign alu_in1          = alu_in1_q;
    assign alu_in2          = alu_in2_q;
    assign out_result       = out_result_q;
    assign out_kind         = out_kind_q;
    assign out_rd           = out_rd_q;
    assign out_branch_taken = out_branch_taken_q;
    assign out_illegal      = out_illegal_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Testbench for alu_op_issue: behavioural ALU, instruction-semantics reference model,
// directed cases followed by randomized instructions.
module tb_alu_op_issue;

    localparam int XLEN   = 64;
    localparam int SETTLE = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data;
    logic [3:0]      alu_opr;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_result;
    logic            alu_branch_mux;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_result;
    logic [1:0]      out_kind;
    logic [4:0]      out_rd;
    logic            out_branch_taken, out_illegal;

    int n_err = 0;
    int n_chk = 0;

    alu_op_issue #(.XLEN(XLEN), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .alu_opr(alu_opr), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_branch_mux(alu_branch_mux),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_kind(out_kind), .out_rd(out_rd),
        .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external ALU
    always_comb begin
        alu_result     = '0;
        alu_branch_mux = 1'b1;
        case (alu_opr)
            4'h0: alu_result = alu_in1 + alu_in2;
            4'h1: alu_result = alu_in1 - alu_in2;
            4'h2: alu_result = alu_in1 << alu_in2[5:0];
            4'h3: alu_result = alu_in1 ^ alu_in2;
            4'h4: alu_result = alu_in1 >> alu_in2[5:0];
            4'h5: alu_result = alu_in1 | alu_in2;
            4'h6: alu_result = alu_in1 & alu_in2;
            4'h7: alu_branch_mux = !(alu_in1 == alu_in2);
            4'h8: alu_branch_mux = !(alu_in1 != alu_in2);
            4'h9: alu_branch_mux = !($signed(alu_in1) < $signed(alu_in2));
            4'hA: alu_branch_mux = !($signed(alu_in1) >= $signed(alu_in2));
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        ill;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        taken;
        logic [3:0]  opr;
        logic [63:0] in2;
    } exp_t;

    // Reference: what the instruction means architecturally
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] immi, imms, sh;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3   = ins[14:12];
        f7   = ins[31:25];
        immi = {{52{ins[31]}}, ins[31:20]};
        imms = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        sh   = {58'd0, ins[25:20]};
        e.ill = 1'b1; e.kind = 2'd0; e.rd = 5'd0; e.res = 64'd0;
        e.taken = 1'b0; e.opr = 4'hF; e.in2 = 64'd0;
        if (ins[6:0] == 7'h33) begin
            e.in2 = b;
            if (f7 == 7'h20 && f3 == 3'd0) begin e.ill = 0; e.res = a - b; e.opr = 4'h1; end
            else if (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) begin
                e.ill = 0;
                case (f3)
                    3'd0: begin e.res = a + b;         e.opr = 4'h0; end
                    3'd1: begin e.res = a << b[5:0];   e.opr = 4'h2; end
                    3'd4: begin e.res = a ^ b;         e.opr = 4'h3; end
                    3'd5: begin e.res = a >> b[5:0];   e.opr = 4'h4; end
                    3'd6: begin e.res = a | b;         e.opr = 4'h5; end
                    default: begin e.res = a & b;      e.opr = 4'h6; end
                endcase
            end
            if (!e.ill) e.rd = ins[11:7];
        end else if (ins[6:0] == 7'h13) begin
            e.in2 = immi;
            case (f3)
                3'd0: begin e.ill = 0; e.res = a + immi; e.opr = 4'h0; end
                3'd4: begin e.ill = 0; e.res = a ^ immi; e.opr = 4'h3; end
                3'd6: begin e.ill = 0; e.res = a | immi; e.opr = 4'h5; end
                3'd7: begin e.ill = 0; e.res = a & immi; e.opr = 4'h6; end
                3'd1: if (ins[31:26] == 0) begin e.ill = 0; e.in2 = sh; e.res = a << ins[25:20]; e.opr = 4'h2; end
                3'd5: if (ins[31:26] == 0) begin e.ill = 0; e.in2 = sh; e.res = a >> ins[25:20]; e.opr = 4'h4; end
                default: ;
            endcase
            if (!e.ill) e.rd = ins[11:7];
        end else if (ins[6:0] == 7'h03) begin
            e.ill = 0; e.kind = 2'd1; e.rd = ins[11:7]; e.res = a + immi; e.opr = 4'h0; e.in2 = immi;
        end else if (ins[6:0] == 7'h23) begin
            e.ill = 0; e.kind = 2'd2; e.res = a + imms; e.opr = 4'h0; e.in2 = imms;
        end else if (ins[6:0] == 7'h63) begin
            e.in2 = b;
            case (f3)
                3'd0: begin e.ill = 0; e.taken = (a == b);                  e.opr = 4'h7; end
                3'd1: begin e.ill = 0; e.taken = (a != b);                  e.opr = 4'h8; end
                3'd4: begin e.ill = 0; e.taken = ($signed(a) < $signed(b));  e.opr = 4'h9; end
                3'd5: begin e.ill = 0; e.taken = ($signed(a) >= $signed(b)); e.opr = 4'hA; end
                default: ;
            endcase
            if (!e.ill) e.kind = 2'd3;
        end
        return e;
    endfunction

    // Issue one instruction, follow it through EXEC, check the result, then retire it
    task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b, input int hold);
        exp_t        e;
        int          n, exec_cyc;
        logic [3:0]  seen_opr;
        logic [63:0] seen_in1, seen_in2;
        e = ref_model(ins, a, b);
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        out_ready   = (hold == 0);
        in_valid    = 1'b1;
        in_instr    = ins;
        in_rs1_data = a;
        in_rs2_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = $urandom;
        n = 0; exec_cyc = 0; seen_opr = 4'hF; seen_in1 = '0; seen_in2 = '0;
        while (!out_valid && n < 20) begin
            if (alu_opr != 4'hF) begin
                exec_cyc++;
                seen_opr = alu_opr; seen_in1 = alu_in1; seen_in2 = alu_in2;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", out_valid, 1);
        end else begin
            chk("latency", n, e.ill ? 1 : SETTLE + 1);
            chk("exec_cycles", exec_cyc, e.ill ? 0 : SETTLE);
            if (!e.ill) begin
                chk("alu_opr", seen_opr, e.opr);
                chk("alu_in1", seen_in1, a);
                chk("alu_in2", seen_in2, e.in2);
            end
            chk("alu_opr_done_nop", alu_opr, 4'hF);
            chk("out_result", out_result, e.res);
            chk("out_kind", out_kind, e.kind);
            chk("out_rd", out_rd, e.rd);
            chk("out_taken", out_branch_taken, e.taken);
            chk("out_illegal", out_illegal, e.ill);
            chk("in_ready_busy", in_ready, 0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_instr = $urandom;
                in_rs1_data = {$urandom, $urandom};
                chk("hold_valid", out_valid, 1);
                chk("hold_result", out_result, e.res);
                chk("hold_kind", out_kind, e.kind);
                chk("hold_ready", in_ready, 0);
            end
            if (hold > 0) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk("retire_valid", out_valid, 0);
            chk("retire_ready", in_ready, 1);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [63:0] a, b;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd, r1, r2;
        logic [11:0] imm;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_rs1_data = '0; in_rs2_data = '0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_opr", alu_opr, 4'hF);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_out_result", out_result, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        issue(32'h002081B3, 64'd5, 64'd7, 0);
        issue(32'h402081B3, 64'd5, 64'd7, 0);
        issue(32'hFFF08193, 64'd5, 64'd0, 0);
        issue(32'h00208063, 64'd9, 64'd9, 0);
        issue(32'h00209063, 64'd9, 64'd9, 0);
        issue(32'h0000007F, 64'd1, 64'd2, 0);
        issue(32'h4050D193, 64'h80, 64'd0, 0);  // srai: not supported
        issue(32'h03F09193, 64'd1, 64'd0, 0);   // slli by 63
        issue(32'h002081B3, 64'd5, 64'd7, 5);

        // reset in the middle of EXEC
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_data = 64'd20; in_rs2_data = 64'd22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_exec_opr", alu_opr, 4'h0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_opr", alu_opr, 4'hF);
        chk("mid_rst_in1", alu_in1, 0);
        chk("mid_rst_in2", alu_in2, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("mid_rst_no_done", out_valid, 0);

        for (int k = 0; k < 60; k++) begin
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
            f3 = 3'($urandom);
            imm = 12'($urandom);
            case ($urandom_range(0, 5))
                0: begin
                    case ($urandom_range(0, 2))
                        0: f7 = 7'h00;
                        1: f7 = 7'h20;
                        default: f7 = 7'($urandom);
                    endcase
                    ins = {f7, r2, r1, f3, rd, 7'h33};
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) imm[11:6] = 6'd0;
                    ins = {imm, r1, f3, rd, 7'h13};
                end
                2: ins = {imm, r1, 3'b011, rd, 7'h03};
                3: ins = {imm[11:5], r2, r1, 3'b011, imm[4:0], 7'h23};
                4: ins = {7'($urandom), r2, r1, f3, 5'($urandom), 7'h63};
                default: ins = $urandom;
            endcase
            issue(ins, a, b, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
